// File: rtl/add_pipe.sv
// Chunked ripple-carry adder/subtractor with ready/valid handshake and per-stage stall control.
// Define ADD_PIPE_OVF_EN to add the registered signed-overflow output.
module add_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_a,
  input  logic [0:WIDTH-1] in_b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] sum,
  output logic             carry_out
`ifdef ADD_PIPE_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned S  = WIDTH / CHUNK;
  localparam int unsigned CW = CHUNK + 1;

  logic [WIDTH-1:0] a_in_c;
  logic [WIDTH-1:0] b_raw_c;
  logic [WIDTH-1:0] b_eff_c;
  logic             cin_eff_c;

  logic [WIDTH-1:0] a_src_c   [S];
  logic [WIDTH-1:0] b_src_c   [S];
  logic [WIDTH-1:0] sum_src_c [S];
  logic [WIDTH-1:0] sum_d     [S];
  logic [CW-1:0]    part_c    [S];
  logic [S-1:0]     cin_src_c;
  logic [S-1:0]     vld_src_c;
  logic [S-1:0]     carry_d;
  logic [S-1:0]     load_c;
  logic             blocked_c;

  logic [S-1:0]     valid_q;
  logic [S-1:0]     carry_q;
  logic [WIDTH-1:0] a_q   [S];
  logic [WIDTH-1:0] b_q   [S];
  logic [WIDTH-1:0] sum_q [S];
  logic             rdy_q;

  // Ports use [0:WIDTH-1] with index 0 as LSB; map onto conventional [WIDTH-1:0] vectors.
  always_comb begin
    a_in_c  = '0;
    b_raw_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      a_in_c[i]  = in_a[i];
      b_raw_c[i] = in_b[i];
    end
    b_eff_c   = sub ? ~b_raw_c : b_raw_c;
    cin_eff_c = sub ? 1'b1 : carry_in;
  end

  // A stage may load when it, and every stage downstream of it, is not stuck holding a beat.
  always_comb begin
    load_c    = '0;
    blocked_c = !out_ready;
    for (int k = int'(S) - 1; k >= 0; k--) begin
      blocked_c = blocked_c && valid_q[k];
      load_c[k] = !blocked_c;
    end
  end

  // Stage k adds chunk k of the operands carried alongside its beat.
  always_comb begin
    a_src_c[0]   = a_in_c;
    b_src_c[0]   = b_eff_c;
    sum_src_c[0] = '0;
    cin_src_c    = '0;
    vld_src_c    = '0;
    cin_src_c[0] = cin_eff_c;
    vld_src_c[0] = in_valid && rdy_q;
    for (int k = 1; k < int'(S); k++) begin
      a_src_c[k]   = a_q[k-1];
      b_src_c[k]   = b_q[k-1];
      sum_src_c[k] = sum_q[k-1];
      cin_src_c[k] = carry_q[k-1];
      vld_src_c[k] = valid_q[k-1];
    end
    carry_d = '0;
    for (int k = 0; k < int'(S); k++) begin
      part_c[k] = CW'(a_src_c[k][k*CHUNK +: CHUNK]) + CW'(b_src_c[k][k*CHUNK +: CHUNK])
                + CW'(cin_src_c[k]);
      sum_d[k]  = sum_src_c[k];
      sum_d[k][k*CHUNK +: CHUNK] = part_c[k][CHUNK-1:0];
      carry_d[k] = part_c[k][CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < int'(S); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      for (int k = 0; k < int'(S); k++) begin
        if (load_c[k]) begin
          valid_q[k] <= vld_src_c[k];
          if (vld_src_c[k]) begin
            a_q[k]     <= a_src_c[k];
            b_q[k]     <= b_src_c[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
    end
  end

`ifdef ADD_PIPE_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Overflow is resolved in the last stage, where the sum MSB is produced.
  always_comb begin
    ovf_d = (a_src_c[S-1][WIDTH-1] == b_src_c[S-1][WIDTH-1])
         && (sum_d[S-1][WIDTH-1] != a_src_c[S-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (load_c[S-1] && vld_src_c[S-1]) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

  // Reset release is retimed through rdy_q so no beat is taken on the releasing edge.
  assign in_ready  = rdy_q && load_c[0];
  assign out_valid = valid_q[S-1];
  assign carry_out = carry_q[S-1];

  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i] = sum_q[S-1][i];
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe (WIDTH=16, CHUNK=4): latency, carries, subtract, stall, reset.
module tb_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:15] in_a;
  logic [0:15] in_b;
  logic        carry_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] sum;
  logic        carry_out;
`ifdef ADD_PIPE_OVF_EN
  logic        overflow;
`endif

  typedef struct packed {logic [15:0] s; logic c; logic o;} exp_t;
  typedef struct packed {logic [15:0] a; logic [15:0] b; logic ci; logic sb;} vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  add_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry_out(carry_out)
`ifdef ADD_PIPE_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [0:15] to_port(input logic [15:0] v);
    logic [0:15] r;
    for (int i = 0; i < 16; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [15:0] from_port(input logic [0:15] p);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = p[i];
    return r;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t        e;
    logic [15:0] eb;
    logic [16:0] f;
    eb  = v.sb ? ~v.b : v.b;
    f   = {1'b0, v.a} + {1'b0, eb} + 17'(v.sb ? 1'b1 : v.ci);
    e.s = f[15:0];
    e.c = f[16];
    e.o = (v.a[15] == eb[15]) && (f[15] != v.a[15]);
    return e;
  endfunction

  task automatic drive(input logic vld, input vec_t v);
    in_valid = vld;
    in_a     = to_port(v.a);
    in_b     = to_port(v.b);
    carry_in = v.ci;
    sub      = v.sb;
  endtask

  // Samples handshake outcome of the coming edge; called just after a falling edge.
  task automatic sample(output bit acc, output bit xfer, output exp_t got);
    #1;
    acc   = in_valid && in_ready;
    xfer  = out_valid && out_ready;
    got.s = from_port(sum);
    got.c = carry_out;
`ifdef ADD_PIPE_OVF_EN
    got.o = overflow;
`else
    got.o = 1'b0;
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.a  = 16'($urandom);
    v.b  = 16'($urandom);
    v.ci = 1'($urandom);
    v.sb = 1'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    vec_t z;
    z = '0;
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, z);
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (from_port(sum) !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got=%h want=0000", from_port(sum)); end
    n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b want=0", carry_out); end
`ifdef ADD_PIPE_OVF_EN
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b want=0", overflow); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_out_valid got=%b want=0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_latency();
    vec_t v;
    bit   acc, xfer;
    exp_t got, e;
    int   cnt;
    v = '{a: 16'h00FF, b: 16'h0001, ci: 1'b0, sb: 1'b0};
    out_ready = 1'b1;
    drive(1'b1, v);
    sample(acc, xfer, got);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL latency_accept got=%b want=1", acc); end
    exp_q.push_back(model(v));
    adv();
    drive(1'b0, v);
    cnt = 0;
    while (cnt < 10) begin
      #1;
      if (out_valid) break;
      adv();
      cnt++;
    end
    n_checks++; if (cnt !== 3) begin n_fail++; $display("FAIL latency_edges got=%0d want=3", cnt); end
    n_checks++; if (from_port(sum) !== 16'h0100) begin n_fail++; $display("FAIL latency_sum got=%h want=0100", from_port(sum)); end
    n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL latency_carry got=%b want=0", carry_out); end
    e = exp_q.pop_front();
    n_checks++; if (from_port(sum) !== e.s) begin n_fail++; $display("FAIL latency_model_sum got=%h want=%h", from_port(sum), e.s); end
    adv();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_drained got=%b want=0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_stream(input string name, input vec_t vecs[$], input int rate_in, input int rate_out,
                             input int budget);
    bit   acc, xfer;
    exp_t got, e;
    int   idx, got_n, n;
    logic vld;
    n = vecs.size();
    idx = 0; got_n = 0;
    for (int cyc = 0; cyc < budget && got_n < n; cyc++) begin
      vld = (idx < n) && (int'($urandom_range(99)) < rate_in);
      drive(vld, (idx < n) ? vecs[idx] : vec_t'('0));
      out_ready = (int'($urandom_range(99)) < rate_out);
      sample(acc, xfer, got);
      if (rate_in == 100 && rate_out == 100 && idx < n) begin
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL %s_throughput cyc=%0d in_ready=%b want=1", name, cyc, in_ready); end
      end
      if (xfer) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL %s_spurious got=%h want=none", name, got.s);
        end else begin
          e = exp_q.pop_front();
          got_n++;
          n_checks++; if (got.s !== e.s) begin n_fail++; $display("FAIL %s_sum beat=%0d got=%h want=%h", name, got_n, got.s, e.s); end
          n_checks++; if (got.c !== e.c) begin n_fail++; $display("FAIL %s_carry beat=%0d got=%b want=%b", name, got_n, got.c, e.c); end
`ifdef ADD_PIPE_OVF_EN
          n_checks++; if (got.o !== e.o) begin n_fail++; $display("FAIL %s_overflow beat=%0d got=%b want=%b", name, got_n, got.o, e.o); end
`endif
        end
      end
      if (acc) begin
        exp_q.push_back(model(vecs[idx]));
        idx++;
      end
      adv();
    end
    n_checks++; if (got_n !== n) begin n_fail++; $display("FAIL %s_count got=%0d want=%0d", name, got_n, n); end
    drive(1'b0, vec_t'('0));
  endtask

  task automatic test_vectors();
    vec_t vecs[$];
    vecs.push_back('{a: 16'hFFFF, b: 16'h0000, ci: 1'b1, sb: 1'b0});
    vecs.push_back('{a: 16'h0005, b: 16'h0007, ci: 1'b0, sb: 1'b1});
    vecs.push_back('{a: 16'h7FFF, b: 16'h0001, ci: 1'b0, sb: 1'b0});
    vecs.push_back('{a: 16'h8000, b: 16'h8000, ci: 1'b0, sb: 1'b0});
    vecs.push_back('{a: 16'h0003, b: 16'h0003, ci: 1'b1, sb: 1'b1});
    vecs.push_back('{a: 16'h8000, b: 16'h0001, ci: 1'b0, sb: 1'b1});
    for (int i = 0; i < 20; i++) vecs.push_back(rand_vec());
    test_stream("vectors", vecs, 100, 100, 200);
  endtask

  task automatic test_back_to_back_stall();
    vec_t vecs[$];
    bit   acc, xfer;
    exp_t got, hold, e;
    int   idx, got_n;
    logic hold_v;
    for (int i = 0; i < 10; i++)
      vecs.push_back('{a: 16'(i * 16'h1111), b: 16'(16'h0F0F + i), ci: 1'(i), sb: 1'(i >> 1)});
    idx = 0; got_n = 0; hold = '0; hold_v = 1'b0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1'b1, vecs[idx]);
      sample(acc, xfer, got);
      if (cyc == 4) begin hold = got; hold_v = out_valid; end
      if (cyc > 4) begin
        n_checks++; if (got !== hold || out_valid !== hold_v) begin n_fail++; $display("FAIL stall_stable cyc=%0d got=%h/%b want=%h/%b", cyc, got.s, out_valid, hold.s, hold_v); end
      end
      if (acc) begin exp_q.push_back(model(vecs[idx])); idx++; end
      adv();
    end
    #1;
    n_checks++; if (idx !== 4) begin n_fail++; $display("FAIL stall_accepts got=%0d want=4", idx); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    n_checks++; if (hold_v !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got=%b want=1", hold_v); end
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got_n < 10; cyc++) begin
      drive(idx < 10, vecs[(idx < 10) ? idx : 9]);
      sample(acc, xfer, got);
      if (cyc == 0) begin
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL stall_full_accept got=%b want=1", acc); end
      end
      if (xfer) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL stall_spurious got=%h want=none", got.s);
        end else begin
          e = exp_q.pop_front();
          got_n++;
          n_checks++; if (got.s !== e.s || got.c !== e.c) begin n_fail++; $display("FAIL stall_result beat=%0d got=%h/%b want=%h/%b", got_n, got.s, got.c, e.s, e.c); end
        end
      end
      if (acc) begin exp_q.push_back(model(vecs[idx])); idx++; end
      adv();
    end
    n_checks++; if (got_n !== 10) begin n_fail++; $display("FAIL stall_count got=%0d want=10", got_n); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stall_leftover got=%0d want=0", exp_q.size()); end
    drive(1'b0, vec_t'('0));
  endtask

  task automatic test_reset_midflight();
    bit   acc, xfer;
    exp_t got;
    int   seen;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(cyc < 3, rand_vec());
      sample(acc, xfer, got);
      adv();
    end
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_valid got=%b want=1", out_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (from_port(sum) !== 16'h0000 || carry_out !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got=%h/%b want=0000/0", from_port(sum), carry_out); end
    exp_q.delete();
    drive(1'b0, vec_t'('0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid) seen++;
      adv();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_stale got=%0d want=0", seen); end
  endtask

  task automatic test_random();
    vec_t vecs[$];
    for (int i = 0; i < 60; i++) vecs.push_back(rand_vec());
    test_stream("random", vecs, 70, 60, 1500);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back_stall();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
